// File: rtl/cir_avg_core_if.sv
// cir_avg_core_if: AXI-stream style sample channel carrying one signed sample per beat.
interface cir_avg_core_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/cir_avg_core.sv
// cir_avg_core: coherent circular averager / peak-hold over 2^log_avg packets with threshold gating.
// Optional macro CIR_AVG_PEAK_EN adds per-packet peak index/magnitude reporting.
module cir_avg_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [LEN_W-1:0] seq_len,
    input  logic [2:0]       log_avg,
    input  logic             mode,
    input  logic [WIDTH-1:0] threshold,
    cir_avg_core_if.slave    i_axis,
    cir_avg_core_if.master   o_axis,
    output logic             len_err,
    output logic [15:0]      round_cnt
`ifdef CIR_AVG_PEAK_EN
    ,
    output logic [LEN_W-1:0] peak_idx,
    output logic [WIDTH-1:0] peak_mag,
    output logic             peak_valid
`endif
);
    localparam int unsigned ACC_W = WIDTH + 7;
    localparam int unsigned EXT_W = ACC_W - WIDTH;
    localparam int unsigned DEPTH = 1 << LEN_W;
    localparam int unsigned PKT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DROP, S_DUMP} state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0] cfg_last;
    logic [2:0]       cfg_log;
    logic             cfg_mode;
    logic [WIDTH-1:0] cfg_thr;

    logic [LEN_W-1:0] idx;
    logic [PKT_W-1:0] pkt;
    logic             in_ready;

    logic             o_valid;
    logic             o_last;
    logic [WIDTH-1:0] o_data;

    logic             beat;
    logic             out_hs;
    logic [LEN_W-1:0] eff_last;
    logic [2:0]       eff_log;
    logic             pkt_final;
    logic             err_early;
    logic             err_miss;
    logic             good_beat;

    logic                    s1_valid;
    logic                    s1_first;
    logic [LEN_W-1:0]        s1_idx;
    logic signed [ACC_W-1:0] s1_x;
    logic signed [ACC_W-1:0] s1_old;
    logic signed [ACC_W-1:0] s1_new;

    logic                    rd_en;
    logic [LEN_W-1:0]        rd_addr;
    logic signed [ACC_W-1:0] rd_q;
    logic                    fwd_hit;
    logic signed [ACC_W-1:0] fwd_data;
    logic signed [ACC_W-1:0] acc_mem [DEPTH];

    logic [LEN_W-1:0] rd_idx;
    logic             rd_done;
    logic             d_valid;
    logic             d_last;
    logic             issue;
    logic             load_out;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] mag;
    logic             gate;
    logic [WIDTH-1:0] gated;

    assign i_axis.tready = in_ready;
    assign o_axis.tdata  = o_data;
    assign o_axis.tlast  = o_last;
    assign o_axis.tvalid = o_valid;

    // Next-state and per-beat length classification; config comes straight from inputs on the first beat.
    always_comb begin
        state_nxt = state;
        beat      = i_axis.tvalid && in_ready;
        out_hs    = o_valid && o_axis.tready;
        eff_last  = (state == S_IDLE) ? LEN_W'(seq_len - LEN_W'(1)) : cfg_last;
        eff_log   = (state == S_IDLE) ? log_avg : cfg_log;
        pkt_final = (pkt == ((PKT_W'(1) << eff_log) - PKT_W'(1)));
        err_early = 1'b0;
        err_miss  = 1'b0;
        good_beat = 1'b0;
        case (state)
            S_IDLE, S_ACCUM: begin
                if (beat) begin
                    if (i_axis.tlast && (idx != eff_last)) begin
                        err_early = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (!i_axis.tlast && (idx == eff_last)) begin
                        err_miss  = 1'b1;
                        state_nxt = S_DROP;
                    end else begin
                        good_beat = 1'b1;
                        state_nxt = (i_axis.tlast && pkt_final) ? S_DUMP : S_ACCUM;
                    end
                end
            end
            S_DROP: begin
                if (beat && i_axis.tlast) state_nxt = S_IDLE;
            end
            S_DUMP: begin
                if (out_hs && o_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      state <= S_IDLE;
        else if (clear) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Config latch, beat/packet counters, input ready and length-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_last <= '0;
            cfg_log  <= '0;
            cfg_mode <= 1'b0;
            cfg_thr  <= '0;
            idx      <= '0;
            pkt      <= '0;
            in_ready <= 1'b0;
            len_err  <= 1'b0;
        end else if (clear) begin
            idx      <= '0;
            pkt      <= '0;
            in_ready <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            in_ready <= (state_nxt != S_DUMP);
            len_err  <= err_early || err_miss;
            if (beat && (state == S_IDLE)) begin
                cfg_last <= eff_last;
                cfg_log  <= log_avg;
                cfg_mode <= mode;
                cfg_thr  <= threshold;
            end
            if (good_beat) begin
                if (i_axis.tlast) begin
                    idx <= '0;
                    pkt <= pkt_final ? '0 : pkt + PKT_W'(1);
                end else begin
                    idx <= idx + LEN_W'(1);
                end
            end else if (err_early || err_miss) begin
                idx <= '0;
                pkt <= '0;
            end
        end
    end

    // Update stage: holds the accepted sample while its accumulator word is read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_idx   <= '0;
            s1_x     <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= good_beat;
            if (beat) begin
                s1_first <= (pkt == '0);
                s1_idx   <= idx;
                s1_x     <= {{EXT_W{i_axis.tdata[WIDTH-1]}}, i_axis.tdata};
            end
        end
    end

    always_comb begin
        s1_old = fwd_hit ? fwd_data : rd_q;
        if (s1_first)      s1_new = s1_x;
        else if (cfg_mode) s1_new = (s1_x > s1_old) ? s1_x : s1_old;
        else               s1_new = s1_old + s1_x;
    end

    always_comb begin
        issue    = (state == S_DUMP) && !s1_valid && !rd_done && (!d_valid || load_out);
        load_out = (state == S_DUMP) && d_valid && (!o_valid || o_axis.tready);
        rd_en    = (beat && ((state == S_IDLE) || (state == S_ACCUM))) || issue;
        rd_addr  = issue ? rd_idx : idx;
    end

    // Accumulator RAM; a write landing on the address read in the same cycle is forwarded.
    always_ff @(posedge clk) begin
        if (s1_valid) acc_mem[s1_idx] <= s1_new;
        if (rd_en)    rd_q <= acc_mem[rd_addr];
        fwd_hit  <= s1_valid && rd_en && (s1_idx == rd_addr);
        fwd_data <= s1_new;
    end

    // Output value: scale or truncate, then zero anything under the magnitude threshold.
    always_comb begin
        shifted = WIDTH'(rd_q >>> cfg_log);
        val     = cfg_mode ? rd_q[WIDTH-1:0] : shifted;
        mag     = val[WIDTH-1] ? (~val + WIDTH'(1)) : val;
        gate    = (mag < cfg_thr);
        gated   = gate ? '0 : val;
    end

    // Dump sequencer: read address, read-data slot and the registered output beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_idx    <= '0;
            rd_done   <= 1'b0;
            d_valid   <= 1'b0;
            d_last    <= 1'b0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_data    <= '0;
            round_cnt <= '0;
        end else if (clear) begin
            rd_idx    <= '0;
            rd_done   <= 1'b0;
            d_valid   <= 1'b0;
            d_last    <= 1'b0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_data    <= '0;
            round_cnt <= '0;
        end else begin
            if (state != S_DUMP) begin
                rd_idx  <= '0;
                rd_done <= 1'b0;
                d_valid <= 1'b0;
            end else begin
                if (issue) begin
                    rd_idx  <= rd_idx + LEN_W'(1);
                    rd_done <= (rd_idx == cfg_last);
                    d_last  <= (rd_idx == cfg_last);
                    d_valid <= 1'b1;
                end else if (load_out) begin
                    d_valid <= 1'b0;
                end
            end
            if (load_out) begin
                o_valid <= 1'b1;
                o_data  <= gated;
                o_last  <= d_last;
            end else if (out_hs) begin
                o_valid <= 1'b0;
            end
            if (out_hs && o_last) round_cnt <= round_cnt + 16'd1;
        end
    end

`ifdef CIR_AVG_PEAK_EN
    logic [LEN_W-1:0] d_idx;
    logic [LEN_W-1:0] best_idx;
    logic [WIDTH-1:0] best_mag;
    logic [WIDTH-1:0] gated_mag;

    assign gated_mag = gate ? '0 : mag;

    // Running peak over emitted beats; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_idx      <= '0;
            best_idx   <= '0;
            best_mag   <= '0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            peak_valid <= 1'b0;
        end else if (clear) begin
            d_idx      <= '0;
            best_idx   <= '0;
            best_mag   <= '0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            peak_valid <= 1'b0;
        end else begin
            if (issue) d_idx <= rd_idx;
            if (load_out && ((d_idx == '0) || (gated_mag > best_mag))) begin
                best_mag <= gated_mag;
                best_idx <= d_idx;
            end
            peak_valid <= out_hs && o_last;
            if (out_hs && o_last) begin
                peak_idx <= best_idx;
                peak_mag <= best_mag;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cir_avg_core.sv
// tb_cir_avg_core: directed vectors for cir_avg_core with hand-computed expected packets.
module tb_cir_avg_core;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LEN_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [LEN_W-1:0] seq_len;
    logic [2:0]       log_avg;
    logic             mode;
    logic [WIDTH-1:0] threshold;
    logic             len_err;
    logic [15:0]      round_cnt;
`ifdef CIR_AVG_PEAK_EN
    logic [LEN_W-1:0] peak_idx;
    logic [WIDTH-1:0] peak_mag;
    logic             peak_valid;
`endif

    cir_avg_core_if #(.WIDTH(WIDTH)) i_axis ();
    cir_avg_core_if #(.WIDTH(WIDTH)) o_axis ();

    cir_avg_core #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .seq_len   (seq_len),
        .log_avg   (log_avg),
        .mode      (mode),
        .threshold (threshold),
        .i_axis    (i_axis),
        .o_axis    (o_axis),
        .len_err   (len_err),
        .round_cnt (round_cnt)
`ifdef CIR_AVG_PEAK_EN
        ,
        .peak_idx  (peak_idx),
        .peak_mag  (peak_mag),
        .peak_valid(peak_valid)
`endif
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   pk [8][16];
    int   ev [16];
    int   got_d [16];
    logic got_l [16];
    int   got_n;
    int   lat;
    int   seen;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_pk(input int p, input int a, input int b, input int c, input int d);
        pk[p][0] = a; pk[p][1] = b; pk[p][2] = c; pk[p][3] = d;
    endtask

    task automatic set_ev(input int a, input int b, input int c, input int d);
        ev[0] = a; ev[1] = b; ev[2] = c; ev[3] = d;
    endtask

    task automatic send_beat(input int d, input logic last);
        @(negedge clk);
        i_axis.tdata  = d;
        i_axis.tlast  = last;
        i_axis.tvalid = 1'b1;
        for (int t = 0; t < 50 && !i_axis.tready; t++) @(negedge clk);
        if (!i_axis.tready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic send_round(input int np, input int n);
        for (int p = 0; p < np; p++)
            for (int i = 0; i < n; i++) send_beat(pk[p][i], i == n - 1);
    endtask

    // Collects n output beats under a repeating 4-cycle ready pattern, checking hold-stability on stalls.
    task automatic recv(input int n, input logic [3:0] pat);
        logic        stalled;
        logic [31:0] hd;
        logic        hl;
        stalled = 1'b0;
        hd      = '0;
        hl      = 1'b0;
        got_n   = 0;
        for (int c = 0; c < 300 && got_n < n; c++) begin
            @(negedge clk);
            i_axis.tvalid = 1'b0;
            if (stalled) begin
                check("hold_valid", o_axis.tvalid, 1);
                check("hold_data", {o_axis.tlast, o_axis.tdata}, {hl, hd});
            end
            o_axis.tready = pat[c % 4];
            stalled = o_axis.tvalid && !o_axis.tready;
            hd      = o_axis.tdata;
            hl      = o_axis.tlast;
            if (o_axis.tvalid && o_axis.tready) begin
                got_d[got_n] = $signed(o_axis.tdata);
                got_l[got_n] = o_axis.tlast;
                got_n++;
            end
        end
        if (got_n < n) check("out_timeout", got_n, n);
    endtask

    task automatic expect_pkt(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_d[i], ev[i]);
            check($sformatf("%s_last%0d", tag, i), got_l[i], i == n - 1);
        end
    endtask

    task automatic finish_round(input string tag, input int cnt);
        @(negedge clk);
        check({tag, "_tvalid_low"}, o_axis.tvalid, 0);
        check({tag, "_round_cnt"}, round_cnt, cnt);
    endtask

    task automatic check_err_pulse(input string tag);
        @(negedge clk);
        i_axis.tvalid = 1'b0;
        check({tag, "_len_err_hi"}, len_err, 1);
        @(negedge clk);
        check({tag, "_len_err_lo"}, len_err, 0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        seq_len = '0; log_avg = '0; mode = 1'b0; threshold = '0;
        i_axis.tdata = '0; i_axis.tlast = 1'b0; i_axis.tvalid = 1'b0;
        o_axis.tready = 1'b1;
        repeat (3) @(posedge clk);
        check("rst_tvalid", o_axis.tvalid, 0);
        check("rst_round_cnt", round_cnt, 0);
        check("rst_len_err", len_err, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", i_axis.tready, 1);

        // Average of four identical packets, with latency measurement.
        seq_len = 10'd4; log_avg = 3'd2; mode = 1'b0; threshold = '0;
        for (int p = 0; p < 4; p++) set_pk(p, 4, 8, -4, 1);
        send_round(4, 4);
        o_axis.tready = 1'b0;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            i_axis.tvalid = 1'b0;
            if (o_axis.tvalid) break;
            lat++;
        end
        check("latency", lat, 3);
        recv(4, 4'b1111);
        set_ev(4, 8, -4, 1);
        expect_pkt("avg4", 4);
        finish_round("avg4", 1);

        // Two-packet average with floor rounding, then gated by threshold 2.
        log_avg = 3'd1;
        set_pk(0, 3, -3, 10, 0);
        set_pk(1, 0, 0, 0, -1);
        send_round(2, 4);
        recv(4, 4'b1111);
        set_ev(1, -2, 5, -1);
        expect_pkt("avg2", 4);
        finish_round("avg2", 2);
        threshold = 32'd2;
        send_round(2, 4);
        recv(4, 4'b1111);
        set_ev(0, -2, 5, 0);
        expect_pkt("thr2", 4);
        finish_round("thr2", 3);

        // Peak-hold; config changes after packet 0 must be ignored.
        seq_len = 10'd2; log_avg = 3'd2; mode = 1'b1; threshold = '0;
        set_pk(0, 1, -5, 0, 0);
        set_pk(1, 7, -9, 0, 0);
        set_pk(2, 2, -6, 0, 0);
        set_pk(3, 0, -7, 0, 0);
        send_beat(pk[0][0], 1'b0);
        send_beat(pk[0][1], 1'b1);
        mode = 1'b0; log_avg = 3'd0; threshold = 32'd100;
        for (int p = 1; p < 4; p++) begin
            send_beat(pk[p][0], 1'b0);
            send_beat(pk[p][1], 1'b1);
        end
        recv(2, 4'b1111);
        ev[0] = 7; ev[1] = -5;
        expect_pkt("peak", 2);
        finish_round("peak", 4);

        // Early tlast aborts the round; a following good round still averages.
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clear_round_cnt", round_cnt, 0);
        seq_len = 10'd8; log_avg = 3'd1; mode = 1'b0; threshold = '0;
        for (int i = 0; i < 5; i++) send_beat(i + 1, i == 4);
        check_err_pulse("early");
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_axis.tvalid) seen++;
        end
        check("early_no_output", seen, 0);
        for (int i = 0; i < 8; i++) begin
            pk[0][i] = 2 * (i + 1);
            pk[1][i] = 0;
            ev[i]    = i + 1;
        end
        send_round(2, 8);
        recv(8, 4'b1111);
        expect_pkt("after_err", 8);
        finish_round("after_err", 1);

        // Missing tlast drops until tlast; log_avg=0 passes a packet through.
        seq_len = 10'd2; log_avg = 3'd0;
        send_beat(5, 1'b0);
        send_beat(6, 1'b0);
        check_err_pulse("miss");
        send_beat(7, 1'b0);
        send_beat(8, 1'b1);
        set_pk(0, 9, -10, 0, 0);
        send_round(1, 2);
        recv(2, 4'b1111);
        ev[0] = 9; ev[1] = -10;
        expect_pkt("pass", 2);
        finish_round("pass", 2);

        // Single-sample packets back-to-back: same-address read-modify-write.
        seq_len = 10'd1; log_avg = 3'd3;
        for (int p = 0; p < 8; p++) pk[p][0] = p + 1;
        send_round(8, 1);
        recv(1, 4'b1111);
        ev[0] = 4;
        expect_pkt("fwd", 1);
        finish_round("fwd", 3);

        // Backpressure 1-0-0-1 during dump.
        seq_len = 10'd4; log_avg = 3'd0;
        set_pk(0, 10, -20, 30, -40);
        send_round(1, 4);
        recv(4, 4'b1001);
        set_ev(10, -20, 30, -40);
        expect_pkt("bp", 4);
        finish_round("bp", 4);

        // Most-negative sample counts as magnitude 2^(WIDTH-1).
        seq_len = 10'd1; log_avg = 3'd0; threshold = 32'h8000_0000;
        pk[0][0] = 32'h8000_0000;
        send_round(1, 1);
        recv(1, 4'b1111);
        ev[0] = 32'h8000_0000;
        expect_pkt("minneg_pass", 1);
        finish_round("minneg_pass", 5);
        threshold = 32'h8000_0001;
        send_round(1, 1);
        recv(1, 4'b1111);
        ev[0] = 0;
        expect_pkt("minneg_gate", 1);
        finish_round("minneg_gate", 6);

        // Peak reporting packet.
        seq_len = 10'd4; log_avg = 3'd0; threshold = '0;
        set_pk(0, 0, -9, 9, 3);
        send_round(1, 4);
        recv(4, 4'b1111);
        set_ev(0, -9, 9, 3);
        expect_pkt("pk", 4);
        finish_round("pk", 7);
`ifdef CIR_AVG_PEAK_EN
        check("peak_valid_hi", peak_valid, 1);
        check("peak_idx", peak_idx, 1);
        check("peak_mag", peak_mag, 9);
        @(negedge clk);
        check("peak_valid_lo", peak_valid, 0);
`endif

        // Reset asserted mid-dump drops o_tvalid immediately.
        o_axis.tready = 1'b0;
        send_round(1, 4);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            i_axis.tvalid = 1'b0;
            if (o_axis.tvalid) begin
                seen = 1;
                break;
            end
        end
        check("dump_tvalid", seen, 1);
        #2 reset = 1'b1;
        #1 check("async_rst_tvalid", o_axis.tvalid, 0);
        @(negedge clk);
        reset = 1'b0;
        o_axis.tready = 1'b1;
        @(negedge clk);
        check("post_rst_round_cnt", round_cnt, 0);
        check("post_rst_tvalid", o_axis.tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
